elevator_button_panel: RTL and testbench

ELEVATOR_BUTTON_PANEL -- requirements
Module: elevator_button_panel

---
 rtl/elevator_button_panel.sv | 208 ++++++++++++++++++++
 tb/tb_elevator_button_panel.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/elevator_button_panel.sv
`default_nettype none
// ============================================================================
//  Module   : elevator_button_panel
//  Purpose  : Front end for the seven elevator buttons (3 car, 4 hall).
//             Every button has its own 2-flop synchronizer, debouncer,
//             rising-edge detector and request FSM. The FSM issues one-cycle
//             request pulses to the controller, re-pulses when the
//             controller does not acknowledge in time, and gives up with a
//             sticky error flag after MAX_PULSES attempts. A door chime
//             pulse is generated on each door opening.
//
//  Ports    : clk                           in   clock, rising edge
//             rst_n                         in   async reset, active low
//             raw_car_btn[2:0]              in   car buttons F1/F2/F3
//             raw_hall_btn[3:0]             in   F1up/F2dn/F2up/F3dn
//             elevator_button_out[2:0]      in   controller car requests (ack)
//             floor_button_out[3:0]         in   controller hall requests (ack)
//             door                          in   1 = door open
//             elevator_floor_button_pressed out  car request pulses
//             floor_button_pressed          out  hall request pulses
//             car_lamp / hall_lamp          out  button illumination
//             door_chime                    out  one-cycle door-open pulse
//             req_err[6:0]                  out  sticky no-ack flags
//                                                [6:4]=car, [3:0]=hall
//
//  Revision : 1.0  initial release
// ============================================================================
module elevator_button_panel #(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int RETRY_CYCLES    = 8,
    parameter int MAX_PULSES      = 3
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [2:0] raw_car_btn,
    input  logic [3:0] raw_hall_btn,
    input  logic [2:0] elevator_button_out,
    input  logic [3:0] floor_button_out,
    input  logic       door,
    output logic [2:0] elevator_floor_button_pressed,
    output logic [3:0] floor_button_pressed,
    output logic [2:0] car_lamp,
    output logic [3:0] hall_lamp,
    output logic       door_chime,
    output logic [6:0] req_err
);

    localparam int c_NUM_CH = 7;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_PULSE = 2'd1,
        ST_WAIT  = 2'd2
    } req_state_t;

    // Channels are packed car-above-hall so that the channel index matches
    // the req_err bit layout directly.
    logic [c_NUM_CH-1:0] w_raw;
    logic [c_NUM_CH-1:0] w_ack;
    logic [c_NUM_CH-1:0] w_pulse;
    logic [c_NUM_CH-1:0] w_busy;
    logic [c_NUM_CH-1:0] w_err_set;
    logic [c_NUM_CH-1:0] w_lamp;
    logic [c_NUM_CH-1:0] err_q;
    logic                door_q;
    logic                chime_q;

    assign w_raw = {raw_car_btn, raw_hall_btn};
    assign w_ack = {elevator_button_out, floor_button_out};

    for (genvar i = 0; i < c_NUM_CH; i++) begin : g_chan
        logic       sync1_q;
        logic       sync2_q;
        logic       deb_q;
        logic       deb_prev_q;
        logic [7:0] deb_cnt_q;
        logic       w_rise;
        req_state_t state_q;
        req_state_t state_d;
        logic [2:0] pcnt_q;
        logic [2:0] pcnt_d;
        logic [7:0] timer_q;
        logic [7:0] timer_d;
        logic       w_err;

        // Synchronizer and debouncer. The counter tracks how many
        // consecutive synchronized samples disagree with the debounced
        // level; any agreeing sample restarts it.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                sync1_q    <= 1'b0;
                sync2_q    <= 1'b0;
                deb_q      <= 1'b0;
                deb_prev_q <= 1'b0;
                deb_cnt_q  <= 8'd0;
            end else begin
                sync1_q    <= w_raw[i];
                sync2_q    <= sync1_q;
                deb_prev_q <= deb_q;
                if (sync2_q != deb_q) begin
                    if (deb_cnt_q == 8'(DEBOUNCE_CYCLES - 1)) begin
                        deb_q     <= ~deb_q;
                        deb_cnt_q <= 8'd0;
                    end else begin
                        deb_cnt_q <= deb_cnt_q + 8'd1;
                    end
                end else begin
                    deb_cnt_q <= 8'd0;
                end
            end
        end

        // Only debounced 0->1 transitions count as presses.
        assign w_rise = deb_q & ~deb_prev_q;

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                state_q <= ST_IDLE;
                pcnt_q  <= 3'd0;
                timer_q <= 8'd0;
            end else begin
                state_q <= state_d;
                pcnt_q  <= pcnt_d;
                timer_q <= timer_d;
            end
        end

        // The pulse cycle itself is the first of the RETRY_CYCLES, so the
        // wait timer (cleared on WAIT entry) expires at RETRY_CYCLES-2 and
        // consecutive pulses are exactly RETRY_CYCLES apart.
        always_comb begin
            state_d = state_q;
            pcnt_d  = pcnt_q;
            timer_d = timer_q;
            w_err   = 1'b0;
            case (state_q)
                ST_IDLE: begin
                    pcnt_d  = 3'd0;
                    timer_d = 8'd0;
                    if (w_rise && !w_ack[i]) begin
                        state_d = ST_PULSE;
                    end
                end
                ST_PULSE: begin
                    timer_d = 8'd0;
                    if (w_ack[i]) begin
                        state_d = ST_IDLE;
                        pcnt_d  = 3'd0;
                    end else begin
                        state_d = ST_WAIT;
                        pcnt_d  = pcnt_q + 3'd1;
                    end
                end
                ST_WAIT: begin
                    timer_d = timer_q + 8'd1;
                    if (w_ack[i]) begin
                        state_d = ST_IDLE;
                        pcnt_d  = 3'd0;
                    end else if (timer_q == 8'(RETRY_CYCLES - 2)) begin
                        timer_d = 8'd0;
                        if (pcnt_q == 3'(MAX_PULSES)) begin
                            state_d = ST_IDLE;
                            pcnt_d  = 3'd0;
                            w_err   = 1'b1;
                        end else begin
                            state_d = ST_PULSE;
                        end
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                    pcnt_d  = 3'd0;
                    timer_d = 8'd0;
                end
            endcase
        end

        assign w_pulse[i]   = (state_q == ST_PULSE);
        assign w_busy[i]    = (state_q != ST_IDLE);
        assign w_err_set[i] = w_err;
    end

    // Door history and sticky error flags.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            door_q  <= 1'b0;
            chime_q <= 1'b0;
            err_q   <= '0;
        end else begin
            door_q  <= door;
            chime_q <= door & ~door_q;
            err_q   <= err_q | w_err_set;
        end
    end

    // The acknowledge inputs are not ours to reset, so the lamps are gated
    // with rst_n to keep every output low while reset is asserted.
    assign w_lamp = {c_NUM_CH{rst_n}} & (w_ack | w_busy);

    assign elevator_floor_button_pressed = w_pulse[6:4];
    assign floor_button_pressed          = w_pulse[3:0];
    assign car_lamp                      = w_lamp[6:4];
    assign hall_lamp                     = w_lamp[3:0];
    assign door_chime                    = chime_q;
    assign req_err                       = err_q;

endmodule
`default_nettype wire

// File: tb/tb_elevator_button_panel.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module   : tb_elevator_button_panel
//  Purpose  : Directed bench for elevator_button_panel. Stimulus pushes the
//             expected (cycle, pulse/chime vector) events into a scoreboard
//             queue; a negedge monitor pops and compares whenever any pulse
//             or chime output is high. Lamps and error flags are checked
//             directly at chosen cycles.
//  Revision : 1.0  initial release
// ============================================================================
module tb_elevator_button_panel;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [2:0] raw_car_btn = '0;
    logic [3:0] raw_hall_btn = '0;
    logic [2:0] elevator_button_out = '0;
    logic [3:0] floor_button_out = '0;
    logic       door = 1'b0;
    logic [2:0] elevator_floor_button_pressed;
    logic [3:0] floor_button_pressed;
    logic [2:0] car_lamp;
    logic [3:0] hall_lamp;
    logic       door_chime;
    logic [6:0] req_err;

    elevator_button_panel #(
        .DEBOUNCE_CYCLES(4),
        .RETRY_CYCLES   (8),
        .MAX_PULSES     (3)
    ) dut (
        .clk                          (clk),
        .rst_n                        (rst_n),
        .raw_car_btn                  (raw_car_btn),
        .raw_hall_btn                 (raw_hall_btn),
        .elevator_button_out          (elevator_button_out),
        .floor_button_out             (floor_button_out),
        .door                         (door),
        .elevator_floor_button_pressed(elevator_floor_button_pressed),
        .floor_button_pressed         (floor_button_pressed),
        .car_lamp                     (car_lamp),
        .hall_lamp                    (hall_lamp),
        .door_chime                   (door_chime),
        .req_err                      (req_err)
    );

    always #5 clk = ~clk;

    // Number of rising edges seen so far; stable when read at negedge.
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int tests = 0;
    int fails = 0;

    // Event vector layout: {door_chime, car pulses[2:0], hall pulses[3:0]}
    typedef struct {
        int         cyc;
        logic [7:0] vec;
    } ev_t;
    ev_t sb_q[$];

    task automatic push(input int c, input logic [7:0] v);
        ev_t e;
        e.cyc = c;
        e.vec = v;
        sb_q.push_back(e);
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, required 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Scoreboard monitor
    always @(negedge clk) begin
        logic [7:0] v;
        ev_t        e;
        v = {door_chime, elevator_floor_button_pressed, floor_button_pressed};
        while (sb_q.size() > 0 && sb_q[0].cyc < cyc) begin
            e = sb_q.pop_front();
            tests++;
            fails++;
            $display("FAIL missed_event: required 0x%0h missing at cycle %0d", e.vec, e.cyc);
        end
        if (v != 8'h00) begin
            tests++;
            if (sb_q.size() == 0) begin
                fails++;
                $display("FAIL unexpected_event: got 0x%0h at cycle %0d, required none", v, cyc);
            end else begin
                e = sb_q.pop_front();
                if (e.cyc != cyc || e.vec != v) begin
                    fails++;
                    $display("FAIL event: got 0x%0h at cycle %0d, required 0x%0h at cycle %0d",
                             v, cyc, e.vec, e.cyc);
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int n;
        int m;

        // ---- reset state ----
        tick(3);
        chk("rst_pulses", 32'({elevator_floor_button_pressed, floor_button_pressed}), 32'h0);
        chk("rst_lamps", 32'({car_lamp, hall_lamp}), 32'h0);
        chk("rst_err_chime", 32'({req_err, door_chime}), 32'h0);
        rst_n = 1'b1;
        tick(3);

        // ---- single hall press, ack the cycle after the pulse ----
        n = cyc;
        raw_hall_btn[0] = 1'b1;
        push(n + 7, 8'h01);
        tick(6);
        chk("s1_lamp_before_pulse", 32'(hall_lamp), 32'h0);
        tick(1);
        chk("s1_lamp_at_pulse", 32'(hall_lamp), 32'h1);
        tick(1);
        floor_button_out[0] = 1'b1;
        tick(2);
        raw_hall_btn[0] = 1'b0;
        tick(10);
        chk("s1_lamp_acked", 32'(hall_lamp), 32'h1);
        chk("s1_err", 32'(req_err), 32'h0);
        floor_button_out[0] = 1'b0;
        tick(2);
        chk("s1_lamp_off", 32'(hall_lamp), 32'h0);

        // ---- bouncing car button ----
        n = cyc;
        for (int k = 0; k < 6; k++) begin
            raw_car_btn[2] = (k % 2 == 0);
            tick(1);
        end
        raw_car_btn[2] = 1'b1;
        push(n + 13, 8'h40);
        tick(6);
        chk("s2_lamp_before_pulse", 32'(car_lamp), 32'h0);
        tick(1);
        chk("s2_lamp_at_pulse", 32'(car_lamp), 32'h4);
        tick(1);
        elevator_button_out[2] = 1'b1;
        tick(4);
        raw_car_btn[2] = 1'b0;
        tick(2);
        elevator_button_out[2] = 1'b0;
        tick(3);

        // ---- no acknowledge: three retries then error ----
        n = cyc;
        raw_car_btn[1] = 1'b1;
        push(n + 7, 8'h20);
        push(n + 15, 8'h20);
        push(n + 23, 8'h20);
        tick(30);
        chk("s3_lamp_last_wait", 32'(car_lamp), 32'h2);
        chk("s3_err_not_yet", 32'(req_err), 32'h0);
        tick(1);
        chk("s3_err_set", 32'(req_err), 32'h20);
        chk("s3_lamp_off", 32'(car_lamp), 32'h0);
        raw_car_btn[1] = 1'b0;
        tick(12);
        chk("s3_err_sticky", 32'(req_err), 32'h20);

        // ---- simultaneous hall presses ----
        n = cyc;
        raw_hall_btn[2:1] = 2'b11;
        push(n + 7, 8'h06);
        tick(8);
        floor_button_out[2:1] = 2'b11;
        tick(16);
        chk("s4_lamps", 32'(hall_lamp), 32'h6);
        raw_hall_btn = '0;
        floor_button_out = '0;
        tick(3);
        chk("s4_lamps_off", 32'(hall_lamp), 32'h0);

        // ---- press while already requested; door chime ----
        elevator_button_out[0] = 1'b1;
        tick(1);
        raw_car_btn[0] = 1'b1;
        tick(12);
        chk("s5_lamp_from_ack", 32'(car_lamp), 32'h1);
        raw_car_btn[0] = 1'b0;
        tick(2);
        n = cyc;
        door = 1'b1;
        push(n + 1, 8'h80);
        tick(1);
        chk("s5_chime_high", 32'(door_chime), 32'h1);
        tick(1);
        chk("s5_chime_low", 32'(door_chime), 32'h0);
        tick(5);
        door = 1'b0;
        tick(3);
        chk("s5_err_sticky", 32'(req_err), 32'h20);

        // ---- reset during WAIT_ACK with button held ----
        n = cyc;
        raw_hall_btn[3] = 1'b1;
        push(n + 7, 8'h08);
        tick(10);
        chk("s6_lamp_waiting", 32'(hall_lamp), 32'h8);
        rst_n = 1'b0;
        #1;
        chk("s6_rst_pulses", 32'({elevator_floor_button_pressed, floor_button_pressed}), 32'h0);
        chk("s6_rst_lamps", 32'({car_lamp, hall_lamp}), 32'h0);
        chk("s6_rst_err_chime", 32'({req_err, door_chime}), 32'h0);
        tick(1);
        rst_n = 1'b1;
        m = cyc;
        push(m + 7, 8'h08);
        tick(7);
        chk("s6_lamp_new_pulse", 32'(hall_lamp), 32'h8);
        tick(1);
        floor_button_out[3] = 1'b1;
        tick(4);
        raw_hall_btn[3] = 1'b0;
        floor_button_out[3] = 1'b0;
        elevator_button_out = '0;
        tick(5);

        chk("sb_drained", 32'(sb_q.size()), 32'h0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire
